// File: rtl/game_ctrl.sv
// Tic-tac-toe turn sequencer and referee: conditions the button and switches, commits moves, scans win lines.
// Optional button debounce is enabled by defining GAME_CTRL_DEBOUNCE_EN.
//
// state | meaning
// IDLE  | waiting for a press; validates and commits a move
// CHECK | scanning winning line line_idx for the current mover
// WIN   | mover completed a line; outputs held until a press restarts
// DRAW  | ninth move without a win; outputs held until a press restarts
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [8:0]  switches,
    output logic [17:0] board,
    output logic        turn,
    output logic        busy,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [8:0]  win_line,
    output logic        illegal,
    output logic [3:0]  move_count
);

    typedef enum logic [1:0] {IDLE, CHECK, WIN, DRAW} state_t;

    logic       btn_s1, btn_s2;
    logic [8:0] sw_s1, sw_s2;
    logic       btn_lvl, btn_prev, press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= button;
            btn_s2 <= btn_s1;
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
        end
    end

`ifdef GAME_CTRL_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt;
    logic          db_lvl;

    // Any cycle where the synced input agrees with the debounced level reloads the timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
            db_lvl <= 1'b0;
        end else if (btn_s2 == db_lvl) begin
            db_cnt <= DB_RELOAD;
        end else if (db_cnt == '0) begin
            db_lvl <= btn_s2;
            db_cnt <= DB_RELOAD;
        end else begin
            db_cnt <= db_cnt - CW'(1);
        end
    end

    assign btn_lvl = db_lvl;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES != 0);
    assign btn_lvl = btn_s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev <= 1'b0;
            press    <= 1'b0;
        end else begin
            btn_prev <= btn_lvl;
            press    <= btn_lvl & ~btn_prev;
        end
    end

    function automatic logic [8:0] line_mask_f(input logic [2:0] idx);
        case (idx)
            3'd0:    line_mask_f = 9'b000_000_111;
            3'd1:    line_mask_f = 9'b000_111_000;
            3'd2:    line_mask_f = 9'b111_000_000;
            3'd3:    line_mask_f = 9'b001_001_001;
            3'd4:    line_mask_f = 9'b010_010_010;
            3'd5:    line_mask_f = 9'b100_100_100;
            3'd6:    line_mask_f = 9'b100_010_001;
            default: line_mask_f = 9'b001_010_100;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  line_idx_q, line_idx_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic [8:0]  win_line_q, win_line_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  mc_q, mc_d;

    logic [1:0] mark;
    logic [8:0] occ, line_mask;
    logic       onehot, legal, line_hit;

    always_comb begin
        mark      = turn_q ? 2'b10 : 2'b01;
        line_mask = line_mask_f(line_idx_q);
        occ       = '0;
        line_hit  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            occ[i] = |board_q[2*i +: 2];
            if (line_mask[i] && (board_q[2*i +: 2] != mark))
                line_hit = 1'b0;
        end
        onehot = (|sw_s2) && ((sw_s2 & (sw_s2 - 9'd1)) == 9'd0);
        legal  = onehot && !(|(sw_s2 & occ));
    end

    always_comb begin
        state_d    = state_q;
        line_idx_d = line_idx_q;
        board_d    = board_q;
        turn_d     = turn_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        illegal_d  = 1'b0;
        mc_d       = mc_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    if (legal) begin
                        for (int i = 0; i < 9; i++)
                            if (sw_s2[i])
                                board_d[2*i +: 2] = mark;
                        mc_d       = mc_q + 4'd1;
                        line_idx_d = 3'd0;
                        state_d    = CHECK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (line_hit) begin
                    state_d    = WIN;
                    winner_d   = mark;
                    win_line_d = line_mask;
                end else if (line_idx_q != 3'd7) begin
                    line_idx_d = line_idx_q + 3'd1;
                end else if (mc_q == 4'd9) begin
                    state_d  = DRAW;
                    winner_d = 2'b11;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = IDLE;
                end
            end
            WIN, DRAW: begin
                if (press) begin
                    board_d    = '0;
                    turn_d     = 1'b0;
                    winner_d   = 2'b00;
                    win_line_d = '0;
                    mc_d       = 4'd0;
                    line_idx_d = 3'd0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            line_idx_q <= 3'd0;
            board_q    <= '0;
            turn_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_line_q <= '0;
            illegal_q  <= 1'b0;
            mc_q       <= 4'd0;
        end else begin
            state_q    <= state_d;
            line_idx_q <= line_idx_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            illegal_q  <= illegal_d;
            mc_q       <= mc_d;
        end
    end

    assign board      = board_q;
    assign turn       = turn_q;
    assign busy       = (state_q == CHECK);
    assign game_over  = (state_q == WIN) || (state_q == DRAW);
    assign winner     = winner_q;
    assign win_line   = win_line_q;
    assign illegal    = illegal_q;
    assign move_count = mc_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: table of moves with a small board model feeding a scoreboard queue,
// plus hand sequences for reset during CHECK and (with GAME_CTRL_DEBOUNCE_EN) button bounce.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic [8:0]  switches;
    logic [17:0] board;
    logic        turn, busy, game_over, illegal;
    logic [1:0]  winner;
    logic [8:0]  win_line;
    logic [3:0]  move_count;

`ifdef GAME_CTRL_DEBOUNCE_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 4;
`endif

    game_ctrl #(.DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .button(button), .switches(switches),
        .board(board), .turn(turn), .busy(busy), .game_over(game_over),
        .winner(winner), .win_line(win_line), .illegal(illegal),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] sw;
        logic       ill;
        logic [1:0] win;
        logic [8:0] wl;
        int         busy_n;
    } vec_t;

    typedef struct {
        logic        ill;
        logic [17:0] brd;
        logic        trn;
        logic [3:0]  mc;
        logic [1:0]  win;
        logic [8:0]  wl;
        logic        over;
        int          busy_n;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;

    logic [17:0] m_board;
    logic        m_turn;
    logic [3:0]  m_mc;
    logic        m_over;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [8:0] sw, input logic ill, input logic [1:0] win,
                                input logic [8:0] wl, input int busy_n);
        vec_t v;
        v.sw = sw; v.ill = ill; v.win = win; v.wl = wl; v.busy_n = busy_n;
        return v;
    endfunction

    task automatic model_reset();
        m_board = '0; m_turn = 1'b0; m_mc = 4'd0; m_over = 1'b0;
    endtask

    // Model: restart when a game is over, else commit the mark unless the table marks it illegal.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   nb;
        e.ill = 1'b0; e.win = 2'b00; e.wl = '0; e.busy_n = 0;
        if (m_over) begin
            model_reset();
        end else if (v.ill) begin
            e.ill = 1'b1;
        end else begin
            for (int i = 0; i < 9; i++)
                if (v.sw[i]) m_board[2*i +: 2] = m_turn ? 2'b10 : 2'b01;
            m_mc++;
            e.win = v.win; e.wl = v.wl; e.busy_n = v.busy_n;
            if (v.win == 2'b00) m_turn = ~m_turn;
            else m_over = 1'b1;
        end
        e.brd = m_board; e.trn = m_turn; e.mc = m_mc; e.over = m_over;
        sb.push_back(e);

        switches = v.sw;
        repeat (3) @(posedge clk);
        #1 button = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        check("illegal_pulse", {31'd0, illegal}, {31'd0, sb[0].ill});
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            @(posedge clk);
            #1;
        end
        check("sb_depth", sb.size(), 1);
        e = sb.pop_front();
        check("busy_cycles", nb, e.busy_n);
        check("board", {14'd0, board}, {14'd0, e.brd});
        check("turn", {31'd0, turn}, {31'd0, e.trn});
        check("move_count", {28'd0, move_count}, {28'd0, e.mc});
        check("winner", {30'd0, winner}, {30'd0, e.win});
        check("win_line", {23'd0, win_line}, {23'd0, e.wl});
        check("game_over", {31'd0, game_over}, {31'd0, e.over});
        @(posedge clk);
        #1;
        check("illegal_one_cycle", {31'd0, illegal}, 32'd0);
        button = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_board"}, {14'd0, board}, 32'd0);
        check({tag, "_turn"}, {31'd0, turn}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
        check({tag, "_winner"}, {30'd0, winner}, 32'd0);
        check({tag, "_win_line"}, {23'd0, win_line}, 32'd0);
        check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
        check({tag, "_move_count"}, {28'd0, move_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // first move, illegal moves, then X wins on line 0
        vecs.push_back(mk(9'h001, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h003, 1, 2'b00, 9'h000, 0));
        vecs.push_back(mk(9'h001, 1, 2'b00, 9'h000, 0));
        vecs.push_back(mk(9'h000, 1, 2'b00, 9'h000, 0));
        vecs.push_back(mk(9'h008, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h002, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h010, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h004, 0, 2'b01, 9'h007, 1));
        vecs.push_back(mk(9'h1FF, 0, 2'b00, 9'h000, 0));
        // draw: X0 O1 X2 O4 X3 O5 X7 O6 X8
        vecs.push_back(mk(9'h001, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h002, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h004, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h010, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h008, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h020, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h080, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h040, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h100, 0, 2'b11, 9'h000, 8));
        vecs.push_back(mk(9'h000, 0, 2'b00, 9'h000, 0));
        // X wins on the last line scanned (diagonal 246)
        vecs.push_back(mk(9'h010, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h001, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h004, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h002, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h040, 0, 2'b01, 9'h054, 8));
        vecs.push_back(mk(9'h000, 0, 2'b00, 9'h000, 0));
        // O wins on column 147
        vecs.push_back(mk(9'h001, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h002, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h008, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h010, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h100, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h080, 0, 2'b10, 9'h092, 5));
        vecs.push_back(mk(9'h000, 0, 2'b00, 9'h000, 0));
        // X wins on diagonal 048 with the ninth move: WIN, not DRAW
        vecs.push_back(mk(9'h001, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h004, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h010, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h008, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h002, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h040, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h020, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h080, 0, 2'b00, 9'h000, 8));
        vecs.push_back(mk(9'h100, 0, 2'b01, 9'h111, 7));
        vecs.push_back(mk(9'h000, 0, 2'b00, 9'h000, 0));

        rst = 1'b0; button = 1'b0; switches = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("in_reset");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("after_reset");

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);

        // reset asserted during the fourth CHECK cycle
        switches = 9'h010;
        repeat (3) @(posedge clk);
        #1 button = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        check("mid_check_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_vals("async_reset");
        button = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        run_vec(mk(9'h001, 0, 2'b00, 9'h000, 8));

`ifdef GAME_CTRL_DEBOUNCE_EN
        begin
            int n_since;
            int first_busy;
            logic prev_b;
            int nb;
            switches = 9'h004;
            repeat (3) @(posedge clk);
            #1;
            prev_b = 1'b0;
            n_since = 0;
            first_busy = -1;
            for (int i = 0; i < 20; i++) begin
                button = ((i / 3) % 2 == 0);
                if (button && !prev_b) n_since = 0;
                prev_b = button;
                @(posedge clk);
                n_since++;
                #1;
                if (busy && first_busy < 0) first_busy = n_since;
            end
            while (first_busy < 0 && n_since < 40) begin
                @(posedge clk);
                n_since++;
                #1;
                if (busy) first_busy = n_since;
            end
            check("debounce_accept_edge", first_busy, 12);
            nb = 0;
            while (busy && nb < 20) begin
                nb++;
                @(posedge clk);
                #1;
            end
            m_board[5:4] = m_turn ? 2'b10 : 2'b01;
            m_mc++;
            m_turn = ~m_turn;
            check("debounce_busy_cycles", nb, 8);
            check("debounce_board", {14'd0, board}, {14'd0, m_board});
            check("debounce_move_count", {28'd0, move_count}, {28'd0, m_mc});
            check("debounce_turn", {31'd0, turn}, {31'd0, m_turn});
            button = 1'b0;
            repeat (LAT + 4) @(posedge clk);
            #1;
            check("debounce_single_move", {28'd0, move_count}, {28'd0, m_mc});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
